// File: rtl/td4_pkg.sv
// td4_pkg: shared TD4 core types and field layout for sequencer, decoder and ALU
package td4_pkg;
  localparam int TD4_ADDR_W  = 4;
  localparam int TD4_DATA_W  = 8;
  localparam int TD4_OPC_W   = 4;
  localparam int TD4_IMM_W   = 4;
  localparam int TD4_IMM_LSB = 0;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_BREAK,
    S_FAULTED
  } state_t;
endpackage

// File: rtl/td4_fetch_timer.sv
// td4_fetch_timer: counts FETCH wait cycles and flags the last one allowed before timeout
module td4_fetch_timer #(
  parameter int TIMEOUT = 15,
  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + W'(1);
  end
  assign tc_o = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/td4_sequencer.sv
// td4_sequencer: TD4 fetch/execute controller owning PC and IR with run, step, breakpoint and ROM-timeout fault
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int ADDR_W  = TD4_ADDR_W,
  parameter int DATA_W  = TD4_DATA_W,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RUN,
  input  logic              STEP,
  input  logic              BP_EN,
  input  logic [ADDR_W-1:0] BP_ADDR,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_REQ,
  input  logic              ROM_ACK,
  input  logic [DATA_W-1:0] ROM_DATA,
  input  logic [ADDR_W-1:0] PC_NEXT,
  output logic [3:0]        OPCODE,
  output logic [3:0]        IMM,
  output logic              EXEC_EN,
  output logic [ADDR_W-1:0] PC,
  output logic              HALTED,
  output logic              FAULT,
  output logic [CNT_W-1:0]  INSTR_CNT
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic step_q, step_d;
  logic tc;
  td4_fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk  (CLK),
    .rst  (RESET),
    .clr_i(state_q != S_FETCH || ROM_ACK),
    .en_i (state_q == S_FETCH),
    .tc_o (tc)
  );
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = (RUN || STEP) ? S_FETCH : S_IDLE;
        step_d  = RUN ? 1'b0 : STEP ? 1'b1 : step_q;
      end
      S_FETCH: begin
        state_d = ROM_ACK ? S_EXEC : tc ? S_FAULTED : S_FETCH;
        ir_d    = ROM_ACK ? ROM_DATA : ir_q;
      end
      S_EXEC: begin
        pc_d    = PC_NEXT;
        cnt_d   = cnt_q + CNT_W'(1);
        // a single step must retire without re-tripping the breakpoint it left
        state_d = (step_q || !RUN) ? S_IDLE :
                  (BP_EN && PC_NEXT == BP_ADDR) ? S_BREAK : S_FETCH;
      end
      S_BREAK: begin
        state_d = STEP ? S_FETCH : !RUN ? S_IDLE : S_BREAK;
        step_d  = STEP ? 1'b1 : step_q;
      end
      S_FAULTED: state_d = S_FAULTED;
      default:   state_d = S_IDLE;
    endcase
  end
  assign ROM_ADDR  = pc_q;
  assign PC        = pc_q;
  assign ROM_REQ   = state_q == S_FETCH;
  assign EXEC_EN   = state_q == S_EXEC;
  assign HALTED    = state_q == S_BREAK;
  assign FAULT     = state_q == S_FAULTED;
  assign INSTR_CNT = cnt_q;
  assign OPCODE    = ir_q[DATA_W-1 -: TD4_OPC_W];
  assign IMM       = ir_q[TD4_IMM_LSB +: TD4_IMM_W];
endmodule

// File: tb/tb_td4_sequencer.sv
// tb_td4_sequencer: directed checks of run, step, breakpoint, timeout fault and reset behaviour
module tb_td4_sequencer;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        RUN = 1'b0;
  logic        STEP = 1'b0;
  logic        BP_EN = 1'b0;
  logic [3:0]  BP_ADDR = '0;
  logic [3:0]  ROM_ADDR;
  logic        ROM_REQ;
  logic        ROM_ACK = 1'b0;
  logic [7:0]  ROM_DATA = '0;
  logic [3:0]  PC_NEXT = '0;
  logic [3:0]  OPCODE;
  logic [3:0]  IMM;
  logic        EXEC_EN;
  logic [3:0]  PC;
  logic        HALTED;
  logic        FAULT;
  logic [15:0] INSTR_CNT;
  int vectors = 0;
  int errs = 0;
  td4_sequencer dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .BP_EN(BP_EN), .BP_ADDR(BP_ADDR),
    .ROM_ADDR(ROM_ADDR), .ROM_REQ(ROM_REQ), .ROM_ACK(ROM_ACK), .ROM_DATA(ROM_DATA),
    .PC_NEXT(PC_NEXT), .OPCODE(OPCODE), .IMM(IMM), .EXEC_EN(EXEC_EN), .PC(PC),
    .HALTED(HALTED), .FAULT(FAULT), .INSTR_CNT(INSTR_CNT)
  );
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    RESET = 1'b1;
    RUN = 1'b0;
    STEP = 1'b0;
    ROM_ACK = 1'b0;
    BP_EN = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
  endtask
  initial begin
    int execs;
    do_reset();
    chk("rst_pc", PC, 0);
    chk("rst_addr", ROM_ADDR, 0);
    chk("rst_exec", EXEC_EN, 0);
    chk("rst_req", ROM_REQ, 0);
    chk("rst_halt", HALTED, 0);
    chk("rst_fault", FAULT, 0);
    chk("rst_cnt", INSTR_CNT, 0);
    chk("rst_ir", {OPCODE, IMM}, 0);
    // free-run, zero-latency ROM
    RUN = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      chk("run_exec_en", EXEC_EN, i % 2);
      if (i % 2 == 1) begin
        chk("run_pc", PC, (i / 2) % 16);
        chk("run_imm", IMM, (i / 2) % 16);
        chk("run_opc", OPCODE, 3);
      end
      ROM_ACK = ROM_REQ;
      ROM_DATA = {4'h3, PC};
      PC_NEXT = PC + 4'd1;
      tick();
    end
    chk("run_cnt16", INSTR_CNT, 16);
    chk("run_pc_wrap", PC, 0);
    RUN = 1'b0;
    ROM_ACK = 1'b1;
    tick();
    chk("run_fall_completes", EXEC_EN, 1);
    ROM_ACK = 1'b0;
    PC_NEXT = 4'd1;
    tick();
    chk("run_fall_idle", ROM_REQ, 0);
    chk("run_fall_cnt", INSTR_CNT, 17);
    // single step with 3 wait cycles, stray STEP mid-fetch dropped
    do_reset();
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("step_req_wait", ROM_REQ, 1);
      STEP = (i == 1);
      tick();
    end
    STEP = 1'b0;
    chk("step_req_4th", ROM_REQ, 1);
    ROM_ACK = 1'b1;
    ROM_DATA = 8'h5A;
    PC_NEXT = 4'd1;
    tick();
    ROM_ACK = 1'b0;
    chk("step_exec", EXEC_EN, 1);
    chk("step_req_off", ROM_REQ, 0);
    chk("step_opc", OPCODE, 4'h5);
    tick();
    chk("step_pc", PC, 1);
    chk("step_cnt", INSTR_CNT, 1);
    chk("step_exec_off", EXEC_EN, 0);
    tick();
    chk("step_idle", ROM_REQ, 0);
    tick();
    chk("step_no_queue", ROM_REQ, 0);
    // breakpoint halt and step-out
    do_reset();
    BP_EN = 1'b1;
    BP_ADDR = 4'd5;
    RUN = 1'b1;
    execs = 0;
    for (int i = 0; i < 100 && !HALTED; i++) begin
      if (EXEC_EN) execs++;
      ROM_ACK = ROM_REQ;
      PC_NEXT = PC + 4'd1;
      tick();
    end
    ROM_ACK = 1'b0;
    chk("bp_halted", HALTED, 1);
    chk("bp_pc", PC, 5);
    chk("bp_execs", execs, 5);
    chk("bp_cnt", INSTR_CNT, 5);
    tick();
    tick();
    chk("bp_hold", HALTED, 1);
    chk("bp_hold_req", ROM_REQ, 0);
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    chk("bp_step_halt_off", HALTED, 0);
    chk("bp_step_req", ROM_REQ, 1);
    ROM_ACK = 1'b1;
    PC_NEXT = 4'd6;
    tick();
    ROM_ACK = 1'b0;
    chk("bp_step_exec", EXEC_EN, 1);
    tick();
    RUN = 1'b0;
    chk("bp_step_pc", PC, 6);
    chk("bp_step_halted", HALTED, 0);
    chk("bp_step_idle", ROM_REQ | EXEC_EN, 0);
    chk("bp_step_cnt", INSTR_CNT, 6);
    // ROM timeout fault
    do_reset();
    RUN = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("to_req", ROM_REQ, 1);
      chk("to_fault_early", FAULT, 0);
      tick();
    end
    chk("to_fault", FAULT, 1);
    chk("to_req_drop", ROM_REQ, 0);
    STEP = 1'b1;
    ROM_ACK = 1'b1;
    tick();
    tick();
    STEP = 1'b0;
    ROM_ACK = 1'b0;
    chk("to_sticky", FAULT, 1);
    chk("to_no_exec", EXEC_EN | ROM_REQ, 0);
    do_reset();
    chk("to_reset_clears", FAULT, 0);
    // reset mid-fetch with simultaneous ACK
    RUN = 1'b1;
    tick();
    tick();
    chk("rmf_in_fetch", ROM_REQ, 1);
    RESET = 1'b1;
    ROM_ACK = 1'b1;
    ROM_DATA = 8'hC3;
    PC_NEXT = 4'd7;
    tick();
    RESET = 1'b0;
    RUN = 1'b0;
    ROM_ACK = 1'b0;
    chk("rmf_ir", {OPCODE, IMM}, 0);
    chk("rmf_pc", PC, 0);
    chk("rmf_exec", EXEC_EN, 0);
    tick();
    chk("rmf_exec_after", EXEC_EN, 0);
    // field split of an instruction word
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    ROM_ACK = 1'b1;
    ROM_DATA = 8'hB7;
    PC_NEXT = 4'd9;
    tick();
    ROM_ACK = 1'b0;
    chk("mov_exec", EXEC_EN, 1);
    chk("mov_opc", OPCODE, 4'hB);
    chk("mov_imm", IMM, 4'h7);
    tick();
    chk("mov_pc", PC, 9);
    chk("mov_cnt", INSTR_CNT, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/td4_sequencer.md
Name: td4_sequencer

Overview:
- Fetch/execute controller for the TD4 core: owns the program counter and instruction register, and handshakes with program ROM.
- Emits a single-cycle execute strobe that qualifies the decoder's register-load enables.
- Supports free-run, single-step and breakpoint halt, plus a sticky fault on ROM timeout.
- Sits between the ROM port and the decoder/ALU datapath.

Parameters:
ADDR_W, 4, PC / ROM address width
DATA_W, 8, instruction width; OPCODE = IR[DATA_W-1:DATA_W-4], IMM = IR[3:0]
TIMEOUT, 15, max cycles in FETCH without ROM_ACK before FAULT (>=1)
CNT_W, 16, retired-instruction counter width

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous, active-high reset
RUN  in  1  level; 1 = free-run
STEP  in  1  one-cycle pulse; execute exactly one instruction
BP_EN  in  1  breakpoint enable
BP_ADDR  in  ADDR_W  breakpoint address
ROM_ADDR  out  ADDR_W  fetch address (= PC)
ROM_REQ  out  1  fetch request
ROM_ACK  in  1  ROM data valid this cycle
ROM_DATA  in  DATA_W  instruction word
PC_NEXT  in  ADDR_W  next PC computed by datapath (jump or PC+1)
OPCODE  out  4  IR opcode field to decoder
IMM  out  4  IR immediate field to ALU
EXEC_EN  out  1  one-cycle strobe; datapath registers load only when high
PC  out  ADDR_W  current program counter
HALTED  out  1  high in BREAK state
FAULT  out  1  sticky ROM timeout flag
INSTR_CNT  out  CNT_W  retired instructions

Behaviour:
- Reset: the synchronous active-high reset, sampled on the CLK rising edge, forces state IDLE and clears all of the following to 0: PC, IR, EXEC_EN, ROM_REQ, HALTED, FAULT, INSTR_CNT, wait counter and step flag. Reset wins over every other input in any state, mid-fetch included.
- ROM_ADDR always equals PC. OPCODE and IMM come combinationally from IR.
- States: IDLE, FETCH, EXEC, BREAK, FAULTED.
- IDLE: outputs quiet.
  - RUN=1: go to FETCH with step flag 0.
  - Else STEP=1: go to FETCH with step flag 1.
  - RUN and STEP both high: RUN wins, step flag 0.
- FETCH: ROM_REQ=1, wait counter increments each cycle.
  - ROM_ACK=1: IR <= ROM_DATA, clear counter, go to EXEC. ACK in the first FETCH cycle is legal (minimum latency).
  - Counter reaches TIMEOUT with no ACK: go to FAULTED.
  - ROM_ACK is ignored outside FETCH.
- EXEC: EXEC_EN=1 for exactly this cycle. At the closing edge:
  - PC <= PC_NEXT; INSTR_CNT <= INSTR_CNT+1, wrapping modulo 2^CNT_W.
  - Next state, in priority order:
    - step flag set: IDLE.
    - RUN=0: IDLE.
    - BP_EN=1 and PC_NEXT==BP_ADDR: BREAK.
    - otherwise: FETCH.
- Fetch-to-execute latency: ACK cycle + 1 (EXEC follows ACK by one edge). Minimum throughput: one instruction per 2 cycles.
- PC wraps naturally at 2^ADDR_W; no special handling.
- BREAK: HALTED=1.
  - STEP=1: FETCH, step flag 1. The breakpoint is not rechecked until after that instruction.
  - Else RUN=0: IDLE.
  - Holding RUN=1 stays in BREAK.
- FAULTED: FAULT=1, ROM_REQ=0, EXEC_EN=0. Exits only on reset.
- STEP pulses arriving outside IDLE/BREAK are dropped, not queued.
- RUN falling during FETCH does not abort the fetch; the instruction completes, then IDLE.

Decomposition:
- Shared package td4_pkg holds:
  - state enum (IDLE, FETCH, EXEC, BREAK, FAULTED);
  - opcode field positions and widths;
  - default ADDR_W/DATA_W constants, also used by the decoder and ALU.
- One natural sub-module: td4_fetch_timer (wait counter with clear/enable and terminal-count output).
- Everything else lives in the top FSM.

Test Plan:
- Reset then RUN=1, ROM ACKs the same cycle as each REQ, PC_NEXT=PC+1 → EXEC_EN every 2nd cycle; PC runs 0,1,2,…,15,0; INSTR_CNT=16 after 32 cycles.
- RUN=0, STEP pulse, ACK after 3 wait cycles → ROM_REQ high 4 cycles, one EXEC_EN, PC 0→1, state IDLE, INSTR_CNT=1.
- RUN=1, BP_EN=1, BP_ADDR=5 → after the instruction at PC=4 retires, HALTED=1 and PC=5. One STEP → exactly one EXEC_EN, PC=6, HALTED=0, state IDLE.
- ROM never ACKs, TIMEOUT=15 → FAULT rises after 15 FETCH cycles, ROM_REQ drops, RUN/STEP have no effect; RESET clears FAULT.
- RESET asserted in the middle of FETCH, with ACK arriving the same cycle → IR stays 0, PC=0, no EXEC_EN.
- ROM_DATA=8'hB7 (MOV B,7 style) with PC_NEXT=9 → OPCODE=4'hB, IMM=4'h7 during EXEC; PC=9 afterwards.
